trap_ctrl: RTL and testbench

//  Trap/return sequencer: the initiator side of the CSR file port (csr_w/csr/wd/rd).
//  On an exception it writes mepc, mcause and mstatus, reads mtvec and redirects the PC.
//  On mret it restores mstatus, reads mepc and redirects the PC.

---
 rtl/csr_pkg.sv | 25 ++
 rtl/trap_ctrl_if.sv | 13 +
 rtl/trap_ctrl_vec_calc.sv | 27 ++
 rtl/trap_ctrl.sv | 132 +++++++++++++
 tb/tb_trap_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared CSR definitions for the trap/return sequencer: machine-mode CSR
// addresses, mstatus bit positions and the sequencer state encoding.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;

  // Explicit encodings keep the state values identical to the legacy design.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    T_EPC    = 3'd1,
    T_CAUSE  = 3'd2,
    T_STATUS = 3'd3,
    T_TVEC   = 3'd4,
    M_STATUS = 3'd5,
    M_EPC    = 3'd6,
    REDIRECT = 3'd7
  } trap_state_t;

endpackage

// File: rtl/trap_ctrl_if.sv
// Single CSR file port: the initiator drives write enable, address and write
// data; the CSR file returns combinational read data for the current address.
interface trap_ctrl_if;

  logic        csr_w;
  logic [11:0] csr;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output csr_w, output csr, output wd, input rd);
  modport slave  (input csr_w, input csr, input wd, output rd);

endinterface

// File: rtl/trap_ctrl_vec_calc.sv
// Trap target computation: mtvec base, plus 4*cause for interrupts when
// mtvec selects vectored mode and vectoring is enabled.
module trap_vec_calc
  import csr_pkg::*;
#(
  parameter bit VECTORED = 1'b1
) (
  input  logic [31:0] mtvec,
  input  logic        irq,
  input  logic [29:0] code,
  output logic [31:0] target
);

  logic [31:0] base;
  logic [31:0] offset;

  // Base is always 4-byte aligned; the addition wraps silently at 32 bits.
  always_comb begin
    base   = {mtvec[31:2], 2'b00};
    offset = '0;
    if (VECTORED && (mtvec[1:0] == 2'b01) && irq) begin
      offset = {code, 2'b00};
    end
    target = base + offset;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap/return sequencer. Owns the CSR port while busy: on an exception it
// saves mepc/mcause, updates mstatus and redirects to mtvec; on mret it
// restores mstatus and redirects to mepc. When idle the core's Zicsr access
// passes straight through.
module trap_ctrl
  import csr_pkg::*;
#(
  parameter logic [11:0] A_MSTATUS = CSR_MSTATUS,
  parameter logic [11:0] A_MTVEC   = CSR_MTVEC,
  parameter logic [11:0] A_MEPC    = CSR_MEPC,
  parameter logic [11:0] A_MCAUSE  = CSR_MCAUSE,
  parameter bit          VECTORED  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exc_valid,
  input  logic [31:0]       exc_cause,
  input  logic [31:0]       exc_pc,
  input  logic              mret,
  input  logic              core_csr_w,
  input  logic [11:0]       core_csr,
  input  logic [31:0]       core_wd,
  trap_ctrl_if.master       bus,
  output logic              busy,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc
);

  trap_state_t state_q;
  logic [31:0] pc_q;
  logic [31:0] cause_q;
  logic [31:0] tgt_q;
  logic [31:0] vec_tgt;

  logic        csr_w_c;
  logic [11:0] csr_c;
  logic [31:0] wd_c;

  trap_vec_calc #(.VECTORED(VECTORED)) u_vec (
    .mtvec  (bus.rd),
    .irq    (cause_q[31]),
    .code   (cause_q[29:0]),
    .target (vec_tgt)
  );

  // CSR port mux: core pass-through in IDLE, sequencer accesses otherwise.
  always_comb begin
    csr_w_c = 1'b0;
    csr_c   = core_csr;
    wd_c    = core_wd;
    unique case (state_q)
      IDLE: csr_w_c = core_csr_w;
      T_EPC: begin
        csr_c   = A_MEPC;
        wd_c    = pc_q;
        csr_w_c = 1'b1;
      end
      T_CAUSE: begin
        csr_c   = A_MCAUSE;
        wd_c    = cause_q;
        csr_w_c = 1'b1;
      end
      T_STATUS: begin
        csr_c              = A_MSTATUS;
        wd_c               = bus.rd;
        wd_c[MSTATUS_MPIE] = bus.rd[MSTATUS_MIE];
        wd_c[MSTATUS_MIE]  = 1'b0;
        csr_w_c            = 1'b1;
      end
      T_TVEC: csr_c = A_MTVEC;
      M_STATUS: begin
        csr_c              = A_MSTATUS;
        wd_c               = bus.rd;
        wd_c[MSTATUS_MIE]  = bus.rd[MSTATUS_MPIE];
        wd_c[MSTATUS_MPIE] = 1'b1;
        csr_w_c            = 1'b1;
      end
      M_EPC: csr_c = A_MEPC;
      REDIRECT: csr_w_c = 1'b0;
      default: csr_w_c = 1'b0;
    endcase
    // Writes are gated during reset so an interrupted trap lands nothing more.
    if (rst) begin
      csr_w_c = 1'b0;
    end
  end

  assign bus.csr_w = csr_w_c;
  assign bus.csr   = csr_c;
  assign bus.wd    = wd_c;

  assign busy           = (state_q != IDLE) | exc_valid | mret;
  assign redirect_valid = (state_q == REDIRECT);
  assign redirect_pc    = tgt_q;

  // Sequencer state, latched trap context and redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tgt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (exc_valid) begin
            pc_q    <= exc_pc;
            cause_q <= exc_cause;
            state_q <= T_EPC;
          end else if (mret) begin
            state_q <= M_STATUS;
          end
        end
        T_EPC:    state_q <= T_CAUSE;
        T_CAUSE:  state_q <= T_STATUS;
        T_STATUS: state_q <= T_TVEC;
        T_TVEC: begin
          tgt_q   <= vec_tgt;
          state_q <= REDIRECT;
        end
        M_STATUS: state_q <= M_EPC;
        M_EPC: begin
          tgt_q   <= {bus.rd[31:2], 2'b00};
          state_q <= REDIRECT;
        end
        REDIRECT: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: two instances (vectoring enabled/disabled)
// share stimulus, each attached to its own small CSR file model.
module tb_trap_ctrl;

  localparam logic [11:0] AMS = 12'h300;
  localparam logic [11:0] ATV = 12'h305;
  localparam logic [11:0] AEP = 12'h341;
  localparam logic [11:0] ACA = 12'h342;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_valid;
  logic [31:0] exc_cause;
  logic [31:0] exc_pc;
  logic        mret;
  logic        core_csr_w;
  logic [11:0] core_csr;
  logic [31:0] core_wd;
  logic        busy0, busy1, rv0, rv1;
  logic [31:0] rp0, rp1;

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;

  trap_ctrl_if bus0 ();
  trap_ctrl_if bus1 ();

  trap_ctrl #(.VECTORED(1'b1)) u0 (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .mret(mret), .core_csr_w(core_csr_w), .core_csr(core_csr),
    .core_wd(core_wd), .bus(bus0), .busy(busy0), .redirect_valid(rv0),
    .redirect_pc(rp0)
  );

  trap_ctrl #(.VECTORED(1'b0)) u1 (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .mret(mret), .core_csr_w(core_csr_w), .core_csr(core_csr),
    .core_wd(core_wd), .bus(bus1), .busy(busy1), .redirect_valid(rv1),
    .redirect_pc(rp1)
  );

  always #5 clk = ~clk;

  // CSR file models: index 0..3 = mstatus, mtvec, mepc, mcause; 4 = unmapped.
  logic [31:0] f0 [5];
  logic [31:0] f1 [5];

  function automatic int unsigned idx(input logic [11:0] a);
    case (a)
      AMS:     return 0;
      ATV:     return 1;
      AEP:     return 2;
      ACA:     return 3;
      default: return 4;
    endcase
  endfunction

  assign bus0.rd = (idx(bus0.csr) < 4) ? f0[idx(bus0.csr)] : 32'h0;
  assign bus1.rd = (idx(bus1.csr) < 4) ? f1[idx(bus1.csr)] : 32'h0;

  always @(posedge clk) begin
    if (bus0.csr_w && idx(bus0.csr) < 4) f0[idx(bus0.csr)] <= bus0.wd;
    if (bus1.csr_w && idx(bus1.csr) < 4) f1[idx(bus1.csr)] <= bus1.wd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cwrite(input logic [11:0] a, input logic [31:0] d);
    core_csr_w = 1'b1;
    core_csr   = a;
    core_wd    = d;
    tick();
    core_csr_w = 1'b0;
  endtask

  initial begin
    rst = 1'b1; exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; mret = 1'b0;
    core_csr_w = 1'b1; core_csr = ATV; core_wd = 32'hFFFF_FFFF;
    tick();
    tick();
    #1;
    // Reset state: no write even with core request, no redirect.
    chk("rst_csr_w", {31'd0, bus0.csr_w}, 32'd0);
    chk("rst_rv", {31'd0, rv0}, 32'd0);
    chk("rst_rpc", rp0, 32'd0);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    rst = 1'b0;
    core_csr_w = 1'b0;
    tick();

    // Pass-through write of mtvec.
    core_csr_w = 1'b1; core_csr = ATV; core_wd = 32'h100;
    #1;
    chk("pt_csr_w", {31'd0, bus0.csr_w}, 32'd1);
    chk("pt_busy", {31'd0, busy0}, 32'd0);
    tick();
    core_csr_w = 1'b0;
    chk("pt_mtvec", f0[1], 32'h100);
    cwrite(AMS, 32'h8);

    // Trap: pc=0x40 cause=2; core write attempt during T_CAUSE.
    exc_valid = 1'b1; exc_pc = 32'h40; exc_cause = 32'd2;
    #1;
    chk("trap_busy_N", {31'd0, busy0}, 32'd1);
    tick();
    exc_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 2) begin
        core_csr_w = 1'b1; core_csr = ATV; core_wd = 32'hDEAD;
      end
      #1;
      chk($sformatf("trap_busy_N+%0d", c), {31'd0, busy0}, 32'd1);
      chk($sformatf("trap_rv_N+%0d", c), {31'd0, rv0}, {31'd0, c == 5});
      if (c == 2) begin
        chk("tcause_addr", {20'd0, bus0.csr}, {20'd0, ACA});
        chk("tcause_wd", bus0.wd, 32'd2);
      end
      if (c == 5) chk("trap_rpc", rp0, 32'h100);
      tick();
      core_csr_w = 1'b0;
    end
    #1;
    chk("trap_busy_N+6", {31'd0, busy0}, 32'd0);
    chk("trap_rv_N+6", {31'd0, rv0}, 32'd0);
    chk("trap_mepc", f0[2], 32'h40);
    chk("trap_mcause", f0[3], 32'd2);
    chk("trap_mstatus", f0[0], 32'h80);
    chk("trap_mtvec_kept", f0[1], 32'h100);

    // Vectored interrupt: mtvec=0x101, cause=0x80000007.
    cwrite(ATV, 32'h101);
    exc_valid = 1'b1; exc_pc = 32'h50; exc_cause = 32'h8000_0007;
    tick();
    exc_valid = 1'b0;
    repeat (4) tick();
    #1;
    chk("vec_rv", {31'd0, rv0}, 32'd1);
    chk("vec_rpc", rp0, 32'h11C);
    chk("direct_rv", {31'd0, rv1}, 32'd1);
    chk("direct_rpc", rp1, 32'h100);
    tick();
    chk("vec_mstatus", f0[0], 32'h0);

    // mret: mstatus=0x80, mepc=0x44.
    cwrite(AMS, 32'h80);
    cwrite(AEP, 32'h44);
    mret = 1'b1;
    #1;
    chk("mret_busy_N", {31'd0, busy0}, 32'd1);
    tick();
    mret = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("mret_rv_N+%0d", c), {31'd0, rv0}, {31'd0, c == 3});
      if (c == 3) chk("mret_rpc", rp0, 32'h44);
      tick();
    end
    #1;
    chk("mret_busy_N+4", {31'd0, busy0}, 32'd0);
    chk("mret_mstatus", f0[0], 32'h88);

    // Collision: exception and mret together; mret pulse while busy ignored.
    cwrite(ATV, 32'h100);
    cwrite(AMS, 32'h8);
    exc_valid = 1'b1; mret = 1'b1; exc_pc = 32'h60; exc_cause = 32'd3;
    tick();
    exc_valid = 1'b0; mret = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      chk($sformatf("col_rv_N+%0d", c), {31'd0, rv0}, {31'd0, c == 5});
      tick();
      mret = 1'b0;
    end
    chk("col_mepc", f0[2], 32'h60);
    chk("col_mcause", f0[3], 32'd3);
    chk("col_mstatus", f0[0], 32'h80);
    repeat (3) begin
      #1;
      chk("col_no_extra_rv", {31'd0, rv0}, 32'd0);
      chk("col_idle", {31'd0, busy0}, 32'd0);
      tick();
    end

    // Reset during T_CAUSE: mepc written, mcause untouched, no redirect.
    cwrite(ACA, 32'h55);
    cwrite(AEP, 32'h0);
    exc_valid = 1'b1; exc_pc = 32'h70; exc_cause = 32'd9;
    tick();
    exc_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rstmid_csr_w", {31'd0, bus0.csr_w}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, busy0}, 32'd0);
    chk("rstmid_rpc", rp0, 32'd0);
    chk("rstmid_mepc", f0[2], 32'h70);
    chk("rstmid_mcause", f0[3], 32'h55);
    repeat (4) begin
      chk("rstmid_no_rv", {31'd0, rv0}, 32'd0);
      tick();
    end
    chk("rstmid_mcause_late", f0[3], 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
